// File: rtl/seq_detect_prog.sv
// Runtime-programmable two-pattern serial detector with registered hit pulses.
// Optional saturating hit counter is built only when SEQ_DETECT_CNT_EN is defined.
module seq_detect_prog #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN) + 1,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pat_a,
   input  logic [LEN_W-1:0]   cfg_len_a,
   input  logic [MAX_LEN-1:0] cfg_pat_b,
   input  logic [LEN_W-1:0]   cfg_len_b,
   input  logic               cfg_overlap,
   input  logic               data_valid,
   input  logic               data_in,
   input  logic               cnt_clr,
   output logic               armed,
   output logic               hit_a,
   output logic               hit_b,
   output logic [CNT_W-1:0]   hit_cnt
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

   logic [0:0]         state_q, state_d;
   logic [MAX_LEN-1:0] pat_a_q, pat_a_d;
   logic [MAX_LEN-1:0] pat_b_q, pat_b_d;
   logic [LEN_W-1:0]   len_a_q, len_a_d;
   logic [LEN_W-1:0]   len_b_q, len_b_d;
   logic               ovl_q, ovl_d;
   logic [MAX_LEN-1:0] hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic               hit_a_q, hit_a_d;
   logic               hit_b_q, hit_b_d;
   logic               accept;
   logic [MAX_LEN-1:0] nh;
   logic               match_a, match_b;

   // Low len bits of the new history equal the pattern, with enough bits seen.
   function automatic logic pat_match(
      input logic [MAX_LEN-1:0] h,
      input logic [MAX_LEN-1:0] p,
      input logic [LEN_W-1:0]   len,
      input logic [LEN_W-1:0]   f
   );
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < MAX_LEN; i++) begin
         if (i < int'(len) && h[i] != p[i]) ok = 1'b0;
      end
      return ok && (len != '0) && (len <= MAX_L) &&
             (({1'b0, f} + 1'b1) >= {1'b0, len});
   endfunction

   // Next-state: config latch, history shift, match evaluation.
   always_comb begin
      state_d = state_q;
      pat_a_d = pat_a_q;
      pat_b_d = pat_b_q;
      len_a_d = len_a_q;
      len_b_d = len_b_q;
      ovl_d   = ovl_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      hit_a_d = 1'b0;
      hit_b_d = 1'b0;
      accept  = (state_q == S_RUN) && !cfg_load && data_valid;
      nh      = {hist_q[MAX_LEN-2:0], data_in};
      match_a = pat_match(nh, pat_a_q, len_a_q, fill_q);
      match_b = pat_match(nh, pat_b_q, len_b_q, fill_q);
      if (cfg_load) begin
         state_d = S_RUN;
         pat_a_d = cfg_pat_a;
         pat_b_d = cfg_pat_b;
         len_a_d = cfg_len_a;
         len_b_d = cfg_len_b;
         ovl_d   = cfg_overlap;
         hist_d  = '0;
         fill_d  = '0;
      end else if (accept) begin
         hit_a_d = match_a;
         hit_b_d = match_b;
         hist_d  = nh;
         fill_d  = (fill_q == MAX_L) ? fill_q : fill_q + 1'b1;
         if (!ovl_q && (match_a || match_b)) begin
            hist_d = '0;
            fill_d = '0;
         end
      end
   end

   // Detector state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_a_q <= '0;
         pat_b_q <= '0;
         len_a_q <= '0;
         len_b_q <= '0;
         ovl_q   <= 1'b0;
         hist_q  <= '0;
         fill_q  <= '0;
         hit_a_q <= 1'b0;
         hit_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_a_q <= pat_a_d;
         pat_b_q <= pat_b_d;
         len_a_q <= len_a_d;
         len_b_q <= len_b_d;
         ovl_q   <= ovl_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         hit_a_q <= hit_a_d;
         hit_b_q <= hit_b_d;
      end
   end

   assign armed = (state_q == S_RUN);
   assign hit_a = hit_a_q;
   assign hit_b = hit_b_q;

`ifdef SEQ_DETECT_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   cnt_sum;

   // Saturating add of 0..2 hits per accepted bit; clear wins.
   always_comb begin
      cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(hit_a_d) + (CNT_W+1)'(hit_b_d);
      cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
      if (cnt_clr) cnt_d = '0;
   end

   // Hit counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign hit_cnt = cnt_q;
`else
   logic cnt_clr_unused;
   assign cnt_clr_unused = cnt_clr;
   assign hit_cnt = '0;
`endif

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Runtime-programmable serial pattern detector for two independent patterns, A and B, each up to MAX_LEN bits long. It replaces fixed-pattern detector FSMs on single-bit serial streams. Patterns, lengths and overlap mode are loaded through a configuration strobe. Hits are reported as registered one-cycle pulses, with an optional saturating hit counter. It sits between a serial bit source with a valid qualifier and control logic that acts on hits.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- LEN_W, $clog2(MAX_LEN)+1, width of length fields (derived; do not override)
- CNT_W, 8, hit counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cfg_load  in  1  latch configuration, clear history
- cfg_pat_a  in  MAX_LEN  pattern A; bit [len_a-1] = first-received bit, bit 0 = last
- cfg_len_a  in  LEN_W  pattern A length; 0 or >MAX_LEN disables A
- cfg_pat_b  in  MAX_LEN  pattern B, same convention
- cfg_len_b  in  LEN_W  pattern B length, same rule
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after any hit
- data_valid  in  1  data_in qualifier
- data_in  in  1  serial bit
- cnt_clr  in  1  clear hit_cnt
- armed  out  1  configuration loaded, detector running
- hit_a  out  1  one-cycle pulse, pattern A completed
- hit_b  out  1  one-cycle pulse, pattern B completed
- hit_cnt  out  CNT_W  saturating hit count

## Operation
- States:
  - IDLE (after reset): data ignored, armed=0.
  - RUN: entered on cfg_load, armed=1. cfg_load in RUN reloads the configuration and stays in RUN.
- Config registers reset to 0, so both patterns are disabled until the first load.
- History: shift register hist[MAX_LEN-1:0] plus fill counter fill, saturating at MAX_LEN.
  - On an accepted bit: nh = {hist[MAX_LEN-2:0], data_in}, and fill increments.
- An accepted bit is data_valid=1 in RUN with cfg_load=0.
- Match A when all of the following hold:
  - len_a is valid
  - fill+1 ≥ len_a
  - nh[len_a-1:0] == pat_a[len_a-1:0]
- B uses the same rule with its own pattern and length. Matches are evaluated only on accepted bits.
- Both patterns may match on the same bit; both hit outputs pulse together.
- Overlap mode: history is kept after a hit. For example, pattern 010 on stream 01010 hits twice.
- Non-overlap mode: after any hit (A or B), hist and fill clear, so the next match needs a full len bits. Stream 01010 with 010 hits once.
- cfg_load: latches all cfg_* inputs and clears hist and fill. It does not clear hit_cnt. A data bit presented in the same cycle is discarded.
- Counter:
  - Adds (hit_a_next + hit_b_next), i.e. 0, 1 or 2, per accepted bit.
  - Saturates at 2^CNT_W−1 and never wraps.
  - cnt_clr has priority over an increment in the same cycle; the result is 0.

## Timing
- Reset values: armed=0, hit_a=0, hit_b=0, hit_cnt=0, hist=0, fill=0, state IDLE, cfg registers 0.
- Latency: a bit sampled at edge N produces hit_a/hit_b high during cycle N+1, for exactly one cycle.
- hit_cnt updates at the same edge as the hit outputs.
- Back-to-back accepted bits may produce hits on consecutive cycles.
- data_valid low: no shift and no hit. Gaps of any length between valid bits are transparent.
- rst mid-stream: all state clears at that edge, and outputs are 0 the next cycle. Any pending hit is lost.
- armed rises the cycle after the cfg_load edge.

## Configuration
- SEQ_DETECT_CNT_EN defined:
  - hit_cnt and cnt_clr are functional as described.
- SEQ_DETECT_CNT_EN undefined:
  - No counter register is built.
  - hit_cnt is tied to 0.
  - cnt_clr is ignored.
  - Hit detection is unchanged.

## Test plan
- Overlap, A=010 (len 3), B disabled, stream 0,1,0,1,0 valid every cycle → hit_a pulses on the cycles after the 3rd and 5th bits; hit_cnt=2.
- Non-overlap, A=010, same stream → single hit_a after the 3rd bit; hit_cnt=1.
- A=010, B=10 (len 2), overlap, stream 0,1,0 → hit_a and hit_b both pulse after the 3rd bit; hit_cnt increments by 2.
- Valid gaps: A=11, bits 1,(valid=0 ×3),1 → one hit_a, one cycle after the second valid bit. Rst asserted between the two 1s → no hit; all outputs 0.
- Reload plus data collision: cfg_load with data_valid=1 in the same cycle → that bit is discarded and history is empty. cfg_len_a=0 → hit_a never asserts.
- Counter, CNT_W=2 with the macro defined: 5 hits → hit_cnt holds 3. cnt_clr coincident with a hit → hit_cnt=0. Macro undefined → hit_cnt stays 0.
